// File: rtl/pe_sequencer.sv
// Control sequencer for an array of processing elements: starts a sum pass,
// accumulates per-PE channel sums into an expected background colour,
// then runs a background-removal pass and acknowledges the PEs.
// Outputs are registered from the state register, so each output follows
// the state it reflects by one clock.
module pe_sequencer #(
  parameter int NUM_PE     = 4,
  parameter int SUM_W      = 16,
  parameter int LOG2_TOTAL = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Start,
  input  logic [7:0]              threshold_in,
  input  logic [7:0]              bg_r_in,
  input  logic [7:0]              bg_g_in,
  input  logic [7:0]              bg_b_in,
  input  logic [NUM_PE-1:0]       Qsd,
  input  logic [NUM_PE-1:0]       Qbgd,
  input  logic [NUM_PE*SUM_W-1:0] red_sum_in,
  input  logic [NUM_PE*SUM_W-1:0] green_sum_in,
  input  logic [NUM_PE*SUM_W-1:0] blue_sum_in,
  output logic                    Start_Sum,
  output logic                    Start_BgRemoval,
  output logic                    Ack,
  output logic [7:0]              red_exp,
  output logic [7:0]              green_exp,
  output logic [7:0]              blue_exp,
  output logic [7:0]              threshold,
  output logic [7:0]              desired_bg_r,
  output logic [7:0]              desired_bg_g,
  output logic [7:0]              desired_bg_b,
  output logic                    Busy,
  output logic                    Done,
  output logic                    Error
);

  // Accumulators are wide enough that NUM_PE full-scale sums cannot overflow.
  localparam int ACC_W = SUM_W + $clog2(NUM_PE);
  localparam int IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE, SUM_START, SUM_WAIT, ACCUM, COMPUTE,
    BG_START, BG_WAIT, ACK, DONE, ERROR
  } state_t;

  state_t           state_reg, state_next;
  logic [WD_W-1:0]  wdog_reg;
  logic [IDX_W-1:0] pe_idx_reg;
  logic [ACC_W-1:0] red_acc_reg, green_acc_reg, blue_acc_reg;
  logic             accept;
  logic             idle_like;

  logic [SUM_W-1:0] red_pe   [NUM_PE];
  logic [SUM_W-1:0] green_pe [NUM_PE];
  logic [SUM_W-1:0] blue_pe  [NUM_PE];

  // Split the flat per-PE buses into indexable per-PE slices.
  generate
    for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_unpack
      assign red_pe[gi]   = red_sum_in[gi*SUM_W +: SUM_W];
      assign green_pe[gi] = green_sum_in[gi*SUM_W +: SUM_W];
      assign blue_pe[gi]  = blue_sum_in[gi*SUM_W +: SUM_W];
    end
  endgenerate

  assign idle_like = (state_reg == IDLE) || (state_reg == DONE) || (state_reg == ERROR);
  assign accept    = Start && idle_like;

  // Average and clamp an accumulator to an 8-bit colour.
  function automatic logic [7:0] sat8(input logic [ACC_W-1:0] acc);
    logic [ACC_W-1:0] shifted;
    shifted = acc >> LOG2_TOTAL;
    if (shifted > ACC_W'(255)) return 8'hFF;
    return shifted[7:0];
  endfunction

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic, including the wait-state watchdogs.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE, ERROR: if (accept) state_next = SUM_START;
      SUM_START: state_next = SUM_WAIT;
      SUM_WAIT: begin
        if (&Qsd)                                state_next = ACCUM;
        else if (wdog_reg == WD_W'(TIMEOUT - 1)) state_next = ERROR;
      end
      ACCUM:    if (pe_idx_reg == IDX_W'(NUM_PE - 1)) state_next = COMPUTE;
      COMPUTE:  state_next = BG_START;
      BG_START: state_next = BG_WAIT;
      BG_WAIT: begin
        if (&Qbgd)                               state_next = ACK;
        else if (wdog_reg == WD_W'(TIMEOUT - 1)) state_next = ERROR;
      end
      ACK:      state_next = DONE;
      default:  state_next = IDLE;
    endcase
  end

  // Datapath: watchdog, PE walk, accumulation, colour compute and config latch.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wdog_reg      <= '0;
      pe_idx_reg    <= '0;
      red_acc_reg   <= '0;
      green_acc_reg <= '0;
      blue_acc_reg  <= '0;
      red_exp       <= '0;
      green_exp     <= '0;
      blue_exp      <= '0;
      threshold     <= '0;
      desired_bg_r  <= '0;
      desired_bg_g  <= '0;
      desired_bg_b  <= '0;
    end else begin
      if ((state_reg == SUM_START) || (state_reg == BG_START))
        wdog_reg <= '0;
      else if ((state_reg == SUM_WAIT) || (state_reg == BG_WAIT))
        wdog_reg <= wdog_reg + WD_W'(1);

      if (state_reg == SUM_WAIT) begin
        pe_idx_reg    <= '0;
        red_acc_reg   <= '0;
        green_acc_reg <= '0;
        blue_acc_reg  <= '0;
      end else if (state_reg == ACCUM) begin
        pe_idx_reg    <= pe_idx_reg + IDX_W'(1);
        red_acc_reg   <= red_acc_reg   + ACC_W'(red_pe[pe_idx_reg]);
        green_acc_reg <= green_acc_reg + ACC_W'(green_pe[pe_idx_reg]);
        blue_acc_reg  <= blue_acc_reg  + ACC_W'(blue_pe[pe_idx_reg]);
      end

      if (state_reg == COMPUTE) begin
        red_exp   <= sat8(red_acc_reg);
        green_exp <= sat8(green_acc_reg);
        blue_exp  <= sat8(blue_acc_reg);
      end

      if (accept) begin
        threshold    <= threshold_in;
        desired_bg_r <= bg_r_in;
        desired_bg_g <= bg_g_in;
        desired_bg_b <= bg_b_in;
      end
    end
  end

  // Registered status and handshake outputs decoded from the current state;
  // an accepted Start drops Done/Error and raises Busy at the same edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Start_Sum       <= 1'b0;
      Start_BgRemoval <= 1'b0;
      Ack             <= 1'b0;
      Busy            <= 1'b0;
      Done            <= 1'b0;
      Error           <= 1'b0;
    end else begin
      Start_Sum       <= (state_reg == SUM_START);
      Start_BgRemoval <= (state_reg == BG_START);
      Ack             <= (state_reg == COMPUTE) || (state_reg == ACK);
      Busy            <= accept || !idle_like;
      Done            <= (state_reg == DONE) && !accept;
      Error           <= (state_reg == ERROR) && !accept;
    end
  end

endmodule

// File: tb/tb_pe_sequencer.sv
// Directed testbench for pe_sequencer with hand-computed expectations.
module tb_pe_sequencer;

  localparam int NUM_PE = 4;
  localparam int SUM_W  = 16;

  logic                    Clk = 1'b0;
  logic                    Reset = 1'b1;
  logic                    Start = 1'b0;
  logic [7:0]              threshold_in = '0, bg_r_in = '0, bg_g_in = '0, bg_b_in = '0;
  logic [NUM_PE-1:0]       Qsd = '0, Qbgd = '0;
  logic [NUM_PE*SUM_W-1:0] red_sum_in = '0, green_sum_in = '0, blue_sum_in = '0;
  logic                    Start_Sum, Start_BgRemoval, Ack, Busy, Done, Error;
  logic [7:0]              red_exp, green_exp, blue_exp;
  logic [7:0]              threshold, desired_bg_r, desired_bg_g, desired_bg_b;

  pe_sequencer #(.NUM_PE(NUM_PE), .SUM_W(SUM_W), .LOG2_TOTAL(2), .TIMEOUT(255)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start),
    .threshold_in(threshold_in), .bg_r_in(bg_r_in), .bg_g_in(bg_g_in), .bg_b_in(bg_b_in),
    .Qsd(Qsd), .Qbgd(Qbgd),
    .red_sum_in(red_sum_in), .green_sum_in(green_sum_in), .blue_sum_in(blue_sum_in),
    .Start_Sum(Start_Sum), .Start_BgRemoval(Start_BgRemoval), .Ack(Ack),
    .red_exp(red_exp), .green_exp(green_exp), .blue_exp(blue_exp),
    .threshold(threshold), .desired_bg_r(desired_bg_r), .desired_bg_g(desired_bg_g),
    .desired_bg_b(desired_bg_b), .Busy(Busy), .Done(Done), .Error(Error)
  );

  always #5 Clk = ~Clk;

  int   n_checks = 0, n_pass = 0;
  int   ss_cnt, bg_cnt, ack_cnt, ack_wide, overlap, done_rise;
  logic prev_ack, prev_done;
  int   n;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic clear_mon();
    ss_cnt = 0; bg_cnt = 0; ack_cnt = 0; ack_wide = 0; overlap = 0; done_rise = 0;
    prev_ack = Ack; prev_done = Done;
  endtask

  task automatic sample_mon();
    if (Start_Sum) ss_cnt++;
    if (Start_BgRemoval) bg_cnt++;
    if (Ack && !prev_ack) ack_cnt++;
    if (Ack && prev_ack) ack_wide++;
    if ((int'(Start_Sum) + int'(Start_BgRemoval) + int'(Ack)) > 1) overlap++;
    if (Done && !prev_done) done_rise++;
    prev_ack = Ack; prev_done = Done;
  endtask

  // One clock: outputs are sampled on the falling edge, inputs change after.
  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
    sample_mon();
  endtask

  // Start is seen by exactly one rising edge (edge k).
  task automatic pulse_start();
    Start = 1'b1;
    step();
    Start = 1'b0;
  endtask

  // Waits for Done (which=0) or Error (which=1); n = edges after edge k.
  task automatic wait_sig(input int which, input int max, output int cnt);
    cnt = max;
    for (int i = 0; i < max; i++) begin
      step();
      if ((which == 0 && Done) || (which == 1 && Error)) begin
        cnt = i + 1;
        break;
      end
    end
  endtask

  function automatic logic [63:0] pack4(input logic [15:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic load_basic();
    red_sum_in   = pack4(16'd10, 16'd20, 16'd30, 16'd40);
    green_sum_in = pack4(16'd4, 16'd4, 16'd4, 16'd4);
    blue_sum_in  = pack4(16'd0, 16'd0, 16'd0, 16'd1000);
  endtask

  initial begin
    // Reset, with Start asserted alongside it.
    @(negedge Clk);
    step(); step();
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_error", Error, 0);
    check("rst_red_exp", red_exp, 0);
    check("rst_threshold", threshold, 0);
    threshold_in = 8'd77;
    Start = 1'b1;
    step();
    Start = 1'b0;
    Reset = 1'b0;
    step(); step();
    check("rst_start_busy", Busy, 0);
    check("rst_start_sum", ss_cnt, 0);
    check("rst_start_thr", threshold, 0);

    // Normal pass: averaging, pulse widths, latency, config latch.
    Qsd = 4'hF; Qbgd = 4'hF; load_basic();
    threshold_in = 8'd50; bg_r_in = 8'd11; bg_g_in = 8'd22; bg_b_in = 8'd33;
    clear_mon();
    pulse_start();
    check("a_busy_start", Busy, 1);
    threshold_in = 8'd99;
    wait_sig(0, 40, n);
    check("a_done", Done, 1);
    check("a_latency", n, 11);
    check("a_start_sum_cycles", ss_cnt, 1);
    check("a_bg_start_cycles", bg_cnt, 1);
    check("a_ack_pulses", ack_cnt, 2);
    check("a_ack_wide", ack_wide, 0);
    check("a_overlap", overlap, 0);
    check("a_red_exp", red_exp, 25);
    check("a_green_exp", green_exp, 4);
    check("a_blue_exp", blue_exp, 250);
    check("a_threshold", threshold, 50);
    check("a_bg_r", desired_bg_r, 11);
    check("a_bg_b", desired_bg_b, 33);
    check("a_busy_end", Busy, 0);
    repeat (3) step();
    check("a_done_hold", Done, 1);
    check("a_thr_hold", threshold, 50);

    // Saturation pass, with Start pulsed while waiting in BG_WAIT.
    red_sum_in   = pack4(16'h3FF, 16'h3FF, 16'h3FF, 16'h3FF);
    green_sum_in = pack4(16'h100, 16'h100, 16'h100, 16'h100);
    blue_sum_in  = pack4(16'h0FF, 16'h0FF, 16'h0FF, 16'h0FF);
    threshold_in = 8'd7; Qbgd = 4'h0;
    clear_mon();
    pulse_start();
    check("b_done_clear", Done, 0);
    for (int i = 0; i < 40; i++) begin
      if (bg_cnt != 0) break;
      step();
    end
    check("b_bg_start_seen", bg_cnt, 1);
    step();
    Start = 1'b1;
    step();
    Start = 1'b0;
    repeat (3) step();
    Qbgd = 4'hF;
    wait_sig(0, 40, n);
    check("b_done", Done, 1);
    check("b_red_sat", red_exp, 255);
    check("b_green_sat", green_exp, 255);
    check("b_blue_exact", blue_exp, 255);
    check("b_threshold", threshold, 7);
    repeat (6) step();
    check("b_single_sum", ss_cnt, 1);
    check("b_single_done", done_rise, 1);
    check("b_busy_end", Busy, 0);

    // Watchdog: one PE never reports done.
    Qsd = 4'b0111;
    clear_mon();
    pulse_start();
    wait_sig(1, 400, n);
    check("c_error", Error, 1);
    check("c_error_latency", n, 257);
    check("c_busy", Busy, 0);
    check("c_no_ack", ack_cnt, 0);
    check("c_done", Done, 0);
    step();
    check("c_error_sticky", Error, 1);
    Qsd = 4'hF;
    pulse_start();
    check("c_error_clear", Error, 0);
    wait_sig(0, 40, n);
    check("c_restart_done", Done, 1);
    check("c_restart_latency", n, 11);

    // Reset while accumulating, then a clean pass.
    pulse_start();
    step(); step();
    Reset = 1'b1;
    step();
    check("d_rst_busy", Busy, 0);
    check("d_rst_red_exp", red_exp, 0);
    check("d_rst_threshold", threshold, 0);
    check("d_rst_done", Done, 0);
    check("d_rst_start_sum", Start_Sum, 0);
    Reset = 1'b0;
    step();
    check("d_idle_busy", Busy, 0);
    load_basic();
    threshold_in = 8'd42;
    clear_mon();
    pulse_start();
    wait_sig(0, 40, n);
    check("d_done", Done, 1);
    check("d_latency", n, 11);
    check("d_red_exp", red_exp, 25);
    check("d_threshold", threshold, 42);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pe_sequencer.md
PE_SEQUENCER -- requirements
Module: pe_sequencer

Interface
REQ-001 Parameter NUM_PE, default 4: number of processing elements sequenced.
REQ-002 Parameter SUM_W, default 16: width of each per-PE channel sum.
REQ-003 Parameter LOG2_TOTAL, default 2: log2 of total pixels averaged; expected colour = accumulated sum >> LOG2_TOTAL.
REQ-004 Parameter TIMEOUT, default 255: maximum cycles spent in any wait state before error.
REQ-005 Clk  in  1  single clock; all logic on rising edge.
REQ-006 Reset  in  1  synchronous, active-high; one clock, Clk; no other reset.
REQ-007 Start  in  1  request to run one full sum + background-removal pass.
REQ-008 threshold_in, bg_r_in, bg_g_in, bg_b_in  in  8 each  configuration, sampled on accepted Start.
REQ-009 Qsd  in  NUM_PE  per-PE sum-done flags.
REQ-010 Qbgd  in  NUM_PE  per-PE background-done flags.
REQ-011 red_sum_in, green_sum_in, blue_sum_in  in  NUM_PE*SUM_W each  per-PE sums; PE i at bits [i*SUM_W +: SUM_W].
REQ-012 Start_Sum  out  1  broadcast sum-start pulse to all PEs.
REQ-013 Start_BgRemoval  out  1  broadcast background-removal start pulse.
REQ-014 Ack  out  1  broadcast acknowledge pulse returning PEs to idle.
REQ-015 red_exp, green_exp, blue_exp  out  8 each  computed expected background colour.
REQ-016 threshold, desired_bg_r, desired_bg_g, desired_bg_b  out  8 each  latched configuration.
REQ-017 Busy, Done, Error  out  1 each  status.

Function
REQ-018 States: IDLE, SUM_START, SUM_WAIT, ACCUM, COMPUTE, BG_START, BG_WAIT, ACK, DONE, ERROR; all outputs registered.
REQ-019 Start accepted only in IDLE, DONE or ERROR; on acceptance latch configuration inputs, clear Done and Error, next state SUM_START; Start in any other state ignored.
REQ-020 SUM_START: Start_Sum high for exactly this one cycle; next state SUM_WAIT.
REQ-021 SUM_WAIT: advance to ACCUM in the cycle after all NUM_PE bits of Qsd are sampled high; partial Qsd keeps waiting.
REQ-022 Watchdog counter cleared on entry to SUM_WAIT and BG_WAIT, incremented each cycle there; reaching TIMEOUT -> ERROR.
REQ-023 ACCUM: one PE per cycle, index 0 to NUM_PE-1, add red/green/blue sum slice into three accumulators of width SUM_W+clog2(NUM_PE), cleared on entry; exactly NUM_PE cycles, no overflow possible.
REQ-024 COMPUTE (one cycle): exp = accumulator >> LOG2_TOTAL, saturated to 255 if wider result exceeds 8 bits; Ack high this cycle only.
REQ-025 red_exp/green_exp/blue_exp hold value from COMPUTE until next COMPUTE or Reset.
REQ-026 BG_START: Start_BgRemoval high for exactly one cycle; next BG_WAIT.
REQ-027 BG_WAIT: all Qbgd high -> ACK; same timeout rule as SUM_WAIT.
REQ-028 ACK: Ack high one cycle; next DONE.
REQ-029 DONE: Done high, Busy low, held until accepted Start or Reset.
REQ-030 ERROR: Error high, Busy low, sticky until accepted Start or Reset; Start_Sum/Start_BgRemoval/Ack low.
REQ-031 Busy high in every state except IDLE, DONE, ERROR.
REQ-032 Start_Sum, Start_BgRemoval, Ack never high in the same cycle.
REQ-033 Minimum pass latency with PEs already done: Start edge k -> Done high at cycle k+7+NUM_PE.

Reset
REQ-034 Reset high at a rising edge: state IDLE; all outputs, accumulators, watchdog and latched configuration 0, from any state including mid-pass.
REQ-035 Reset and Start in the same cycle: Reset wins, Start discarded.

Verification
REQ-036 NUM_PE=4, LOG2_TOTAL=2, red sums 10,20,30,40 -> red_exp=25; Start_Sum, Ack, Start_BgRemoval each exactly one cycle; Done after final Ack.
REQ-037 Sums 0x3FF each, LOG2_TOTAL=2 -> red_exp saturates to 255.
REQ-038 Qsd=4'b0111 held 255 cycles -> Error=1, Busy=0, no Ack; subsequent Start clears Error and restarts.
REQ-039 Start pulsed during BG_WAIT -> ignored, single pass, one Done.
REQ-040 Reset asserted in ACCUM -> next cycle state IDLE, all outputs 0; new Start completes normally.
REQ-041 threshold_in=50 at Start, changed to 99 mid-pass -> threshold output stays 50 until next Start.
